// File: rtl/key_conditioner.sv
// Push-button front end: per-key two-flop synchroniser, debounce with
// restart-on-bounce, registered press/release pulses, and an "all keys
// held" qualified reset request with a one-cycle rising-edge pulse.
// Inputs are raw active-low pins; every output is active-high.
module key_conditioner #(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COMBO_CYCLES    = 1024
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [N-1:0] KEY_n,
  output logic [N-1:0] Pressed,
  output logic [N-1:0] Press_pulse,
  output logic [N-1:0] Release_pulse,
  output logic         Combo_reset,
  output logic         Combo_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(COMBO_CYCLES + 1);

  // Count value on which a pending change is finally accepted.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // Combo counter saturation value and the value one below it.
  localparam logic [CW-1:0] CB_FULL = CW'(COMBO_CYCLES);
  localparam logic [CW-1:0] CB_LAST = CW'(COMBO_CYCLES - 1);

  // Synchroniser stages hold raw pin polarity (1 = released).
  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;

  // Per-key debounce counters and their next values.
  logic [DW-1:0] db_cnt      [N];
  logic [DW-1:0] db_cnt_next [N];

  // Next values of the registered per-key outputs.
  logic [N-1:0]  pressed_next;
  logic [N-1:0]  press_next;
  logic [N-1:0]  release_next;

  // Combo hold counter.
  logic [CW-1:0] combo_cnt;
  logic [CW-1:0] combo_cnt_next;
  logic          all_held;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY_n;
      sync2 <= sync1;
    end
  end

  // Debounce decision per key: any cycle agreeing with the accepted level
  // restarts the count, so a bounce shorter than DEBOUNCE_CYCLES never flips.
  always_comb begin
    pressed_next = Pressed;
    press_next   = '0;
    release_next = '0;
    for (int i = 0; i < N; i++) begin
      db_cnt_next[i] = '0;
      if (~sync2[i] == Pressed[i]) begin
        db_cnt_next[i] = '0;
      end else if (db_cnt[i] == DB_LAST) begin
        pressed_next[i] = ~sync2[i];
        press_next[i]   = ~sync2[i];
        release_next[i] = sync2[i];
        db_cnt_next[i]  = '0;
      end else begin
        db_cnt_next[i] = db_cnt[i] + DW'(1);
      end
    end
  end

  // Debounce state and per-key outputs; pulses land with the new level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Pressed       <= '0;
      Press_pulse   <= '0;
      Release_pulse <= '0;
      for (int i = 0; i < N; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      Pressed       <= pressed_next;
      Press_pulse   <= press_next;
      Release_pulse <= release_next;
      for (int i = 0; i < N; i++) begin
        db_cnt[i] <= db_cnt_next[i];
      end
    end
  end

  // Combo counting needs all keys held both now and after this edge: the
  // current level delays the start by one cycle after the keys are accepted,
  // while the next level lets Combo_reset drop on the edge a key is released.
  always_comb begin
    all_held       = (&Pressed) & (&pressed_next);
    combo_cnt_next = '0;
    if (!all_held) begin
      combo_cnt_next = '0;
    end else if (combo_cnt == CB_FULL) begin
      combo_cnt_next = combo_cnt;
    end else begin
      combo_cnt_next = combo_cnt + CW'(1);
    end
  end

  // Combo counter with registered level and rising-edge pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      combo_cnt   <= '0;
      Combo_reset <= 1'b0;
      Combo_pulse <= 1'b0;
    end else begin
      combo_cnt   <= combo_cnt_next;
      Combo_reset <= (combo_cnt_next == CB_FULL);
      Combo_pulse <= (combo_cnt == CB_LAST) && (combo_cnt_next == CB_FULL);
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed steps plus random pin activity,
// compared every cycle against a window-based reference model.
module tb_key_conditioner;

  localparam int N = 2;
  localparam int D = 4;
  localparam int C = 3;

  // Clock / reset
  logic         Clk;
  logic         Reset_n;
  logic [N-1:0] KEY_n;
  logic [N-1:0] Pressed;
  logic [N-1:0] Press_pulse;
  logic [N-1:0] Release_pulse;
  logic         Combo_reset;
  logic         Combo_pulse;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  key_conditioner #(
    .N(N),
    .DEBOUNCE_CYCLES(D),
    .COMBO_CYCLES(C)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .KEY_n(KEY_n),
    .Pressed(Pressed),
    .Press_pulse(Press_pulse),
    .Release_pulse(Release_pulse),
    .Combo_reset(Combo_reset),
    .Combo_pulse(Combo_pulse)
  );

  // Reference model state: raw pin samples taken at each edge, oldest first.
  // A key's accepted level flips at edge t when the samples from edges
  // t-D-1 .. t-2 (two synchroniser stages of delay) all show the opposite level.
  logic [N-1:0] pin_q[$];
  logic [N-1:0] m_pressed;
  logic [N-1:0] m_press;
  logic [N-1:0] m_release;
  logic         m_combo;
  logic         m_cpulse;
  int           all_run;   // consecutive edges after which every key was held

  int compared;
  int mismatched;
  int cycle_no;

  task automatic model_reset();
    pin_q.delete();
    for (int j = 0; j < D + 2; j++) pin_q.push_back('1);
    m_pressed = '0;
    m_press   = '0;
    m_release = '0;
    m_combo   = 1'b0;
    m_cpulse  = 1'b0;
    all_run   = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] new_p;
    logic [N-1:0] s;
    logic         prev_combo;
    bit           all_opp;
    pin_q.push_back(KEY_n);
    if (pin_q.size() > D + 2) void'(pin_q.pop_front());
    new_p = m_pressed;
    for (int i = 0; i < N; i++) begin
      all_opp = 1'b1;
      for (int j = 0; j < D; j++) begin
        s = pin_q[j];
        // pin low means pressed, so a pin bit equal to the pressed bit is the opposite level
        if (s[i] != m_pressed[i]) all_opp = 1'b0;
      end
      if (all_opp) new_p[i] = ~m_pressed[i];
    end
    m_press   = new_p & ~m_pressed;
    m_release = ~new_p & m_pressed;
    m_pressed = new_p;
    if (&new_p) all_run++;
    else all_run = 0;
    prev_combo = m_combo;
    m_combo    = (all_run >= C + 1);
    m_cpulse   = m_combo && !prev_combo;
  endtask

  // Scoreboard comparison of every output against the model.
  task automatic check_all(input string tag);
    compared++;
    assert (Pressed === m_pressed) else begin
      mismatched++;
      $error("FAIL %s Pressed @%0d: observed=%b expected=%b", tag, cycle_no, Pressed, m_pressed);
    end
    compared++;
    assert (Press_pulse === m_press) else begin
      mismatched++;
      $error("FAIL %s Press_pulse @%0d: observed=%b expected=%b", tag, cycle_no, Press_pulse, m_press);
    end
    compared++;
    assert (Release_pulse === m_release) else begin
      mismatched++;
      $error("FAIL %s Release_pulse @%0d: observed=%b expected=%b", tag, cycle_no, Release_pulse, m_release);
    end
    compared++;
    assert (Combo_reset === m_combo) else begin
      mismatched++;
      $error("FAIL %s Combo_reset @%0d: observed=%b expected=%b", tag, cycle_no, Combo_reset, m_combo);
    end
    compared++;
    assert (Combo_pulse === m_cpulse) else begin
      mismatched++;
      $error("FAIL %s Combo_pulse @%0d: observed=%b expected=%b", tag, cycle_no, Combo_pulse, m_cpulse);
    end
  endtask

  // Driver: advance one clock, update the model, then check 1 time unit later.
  task automatic step(input string tag);
    @(posedge Clk);
    cycle_no++;
    if (!Reset_n) model_reset();
    else model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cycle_no   = 0;
    KEY_n      = '1;
    Reset_n    = 1'b0;
    model_reset();

    // Reset held across a few edges, released mid-cycle.
    repeat (3) step("reset");
    #2 Reset_n = 1'b1;

    // Idle with keys released.
    repeat (20) step("idle");

    // Clean press and release of key 0.
    KEY_n[0] = 1'b0;
    repeat (10) step("press0");
    KEY_n[0] = 1'b1;
    repeat (10) step("release0");

    // Bounce every 2 cycles, then held low.
    for (int b = 0; b < 6; b++) begin
      KEY_n[0] = ~KEY_n[0];
      repeat (2) step("bounce2");
    end
    KEY_n[0] = 1'b0;
    repeat (10) step("settle0");
    KEY_n[0] = 1'b1;
    repeat (10) step("release0b");

    // Random-length bounces, all shorter than the debounce window, on key 1.
    for (int b = 0; b < 8; b++) begin
      KEY_n[1] = ~KEY_n[1];
      repeat ($urandom_range(1, D - 1)) step("bounce_rand");
    end
    KEY_n[1] = 1'b1;
    repeat (10) step("settle1");

    // Combo: both pressed, then key 1 released while key 0 stays held.
    KEY_n = 2'b00;
    repeat (12) step("combo");
    KEY_n[1] = 1'b1;
    repeat (8) step("combo_drop");
    KEY_n = '1;
    repeat (8) step("combo_idle");

    // Random pin activity with a mix of short and long holds.
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 3) == 0) KEY_n = 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        KEY_n = 2'b00;
        repeat (10) step("rand_hold");
      end
      step("random");
    end
    KEY_n = '1;
    repeat (10) step("random_idle");

    // Reset asserted mid-combo, keys still held afterwards.
    KEY_n = 2'b00;
    repeat (15) step("combo2");
    compared++;
    assert (Combo_reset === 1'b1) else begin
      mismatched++;
      $error("FAIL combo_before_reset: observed=%b expected=1", Combo_reset);
    end
    #2 Reset_n = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    repeat (2) step("in_reset");
    #2 Reset_n = 1'b1;
    repeat (14) step("post_reset_held");
    compared++;
    assert (Combo_reset === 1'b1 && Pressed === 2'b11) else begin
      mismatched++;
      $error("FAIL post_reset_combo: observed=%b/%b expected=1/11", Combo_reset, Pressed);
    end
    KEY_n = '1;
    repeat (10) step("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end conditioner for the active-low push-buttons (Run, Continue) that feed the SLC-3 top level.
- Per key: synchronises the asynchronous pin, debounces it, and produces an active-high debounced level plus one-cycle press/release pulses.
- Detects the "all keys held" combination and issues a qualified reset request, replacing the raw combinational both-buttons-low reset.
- Sits directly upstream of the SLC-3 top; its outputs drive Run_ah, Continue_ah and Reset_ah.

Parameters:
N, 2, number of keys conditioned.
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a key change; legal range ≥1.
COMBO_CYCLES, 1024, cycles all keys must be held (debounced) before Combo_reset asserts; legal range ≥1.

Ports:
Clk  input  1  system clock; all state on rising edge.
Reset_n  input  1  asynchronous, active-low reset.
KEY_n  input  N  raw button pins, active-low, asynchronous to Clk.
Pressed  output  N  debounced key level, active-high.
Press_pulse  output  N  one-cycle pulse on accepted press.
Release_pulse  output  N  one-cycle pulse on accepted release.
Combo_reset  output  1  high while all keys have been held ≥COMBO_CYCLES.
Combo_pulse  output  1  one-cycle pulse when Combo_reset rises.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - sync flops = 1 (released); stable state = released; all counters = 0.
  - All outputs = 0.
  - Deassertion is released synchronously by the system; no internal reset synchroniser.
- Synchroniser: 2 flops per key (s1, s2). Nothing downstream reads s1.
- Debounce, per key, counter width $clog2(DEBOUNCE_CYCLES+1):
  - Any cycle with s2 == stable: counter cleared to 0.
  - s2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable flips and counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are fully rejected; the counter restarts on each bounce.
- Latency: pin change first captured in s1 at edge k. Pressed changes at edge k+1+DEBOUNCE_CYCLES.
- Pulses are registered and asserted on the same edge the stable state flips, so they align with the first cycle of the new Pressed value.
  - Press_pulse goes high on released→pressed.
  - Release_pulse goes high on pressed→released.
  - Each pulse is exactly 1 cycle and is never asserted simultaneously with the other for the same key.
- Keys are fully independent. Simultaneous flips on different keys each produce their own pulses in the same cycle.
- Combo logic, counter width $clog2(COMBO_CYCLES+1):
  - While all Pressed bits = 1: counter increments, saturating at COMBO_CYCLES.
  - Combo_reset = (counter == COMBO_CYCLES), registered.
  - Combo_pulse is high for the single cycle where the counter transitions COMBO_CYCLES-1 → COMBO_CYCLES.
  - Any Pressed bit = 0: counter cleared on that edge, so Combo_reset drops in the same cycle Pressed falls.
  - Re-holding all keys restarts the count from 0.
- Press pulses are not suppressed during a combo; the consumer gates them if required.
- Reset asserted mid-bounce or mid-combo: all state returns to reset values immediately. After release, any key still held is re-accepted only after a full debounce.
- N=1: combo logic degenerates to a long-hold detector on that key. This is legal.

Test Plan (DEBOUNCE_CYCLES=4, COMBO_CYCLES=3, N=2):
1. Reset then idle, KEY_n=2'b11 → all outputs 0 for 20 cycles. Reset asserted mid-cycle → outputs 0 immediately, without waiting for a clock edge.
2. Clean press: KEY_n[0] falls before edge k → Pressed[0] and Press_pulse[0] rise at edge k+5. Press_pulse[0] lasts 1 cycle. Pressed[1]=0 throughout.
3. Bounce: KEY_n[0] toggles low/high every 2 cycles for 12 cycles, then held low → no pulse during the bounce. Single Press_pulse 5 edges after the last transition.
4. Release: from pressed, KEY_n[0] rises → Release_pulse[0] and Pressed[0]=0 at edge k+5. No Press_pulse is generated.
5. Combo: both keys pressed together → both Press_pulses in the same cycle. Combo_pulse 3 cycles after the Pressed bits rise, then Combo_reset stays high. Releasing key 1 → Combo_reset drops on the same edge that Pressed[1] falls.
6. Reset mid-combo: assert Reset_n=0 while Combo_reset=1 with keys held → all outputs 0 at once. After release with keys still held, Pressed returns at edge +6 and Combo_reset 3 cycles later.
